// File: rtl/ddr_ctrl_arb_pkg.sv
// Shared definitions for the DDR-controller FIFO burst arbiter.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package ddr_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2
  } arb_state_e;

  // Requester-ID width; a single requester still needs a 1-bit ID.
  function automatic int calc_rw(input int req_num);
    return (req_num > 1) ? $clog2(req_num) : 1;
  endfunction

  // FIFO address width; the fill count is one bit wider.
  function automatic int calc_aw(input int fifo_depth);
    return (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  endfunction

endpackage

// File: rtl/ddr_ctrl_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, searching upward with wrap.
// Latency: combinational.
// Backpressure: none; win_vld is simply low when nothing is requesting.
module ddr_ctrl_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int RW      = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [RW-1:0]      ptr,
  output logic [RW-1:0]      win_id,
  output logic               win_vld
);

  // Scan offsets from highest to lowest so the smallest offset from ptr wins last.
  always_comb begin
    logic [RW:0] pos;
    win_id  = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (RW+1)'(k);
      if (pos >= (RW+1)'(REQ_NUM)) begin
        pos = pos - (RW+1)'(REQ_NUM);
      end
      if (req[pos[RW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = pos[RW-1:0];
      end
    end
  end

endmodule

// File: rtl/ddr_ctrl_fifo_arbiter.sv
// Round-robin burst arbiter: admits a whole burst into the shared DDR command/data FIFO only when it fits.
// Latency: request seen in IDLE -> grant next cycle; first beat may be written the cycle the grant shows.
// Backpressure: none inside a burst (space reserved up front); requesters wait via I_Req held until granted.
module ddr_ctrl_fifo_arbiter
  import ddr_ctrl_arb_pkg::*;
#(
  parameter  int REQ_NUM    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int RW         = calc_rw(REQ_NUM),
  localparam int AW         = calc_aw(FIFO_DEPTH)
) (
  input  logic                            Sys_Clk,
  input  logic                            Sys_Rst_N,
  input  logic [REQ_NUM-1:0]              I_Req,
  input  logic [REQ_NUM*LEN_WIDTH-1:0]    I_Req_Len,
  input  logic [REQ_NUM-1:0]              I_Data_Vld,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   I_Req_Data,
  output logic [REQ_NUM-1:0]              O_Grant,
  output logic [REQ_NUM-1:0]              O_Beat_Ack,
  output logic                            O_Fifo_Wr_En,
  output logic [DATA_WIDTH-1:0]           O_Fifo_Wr_Data,
  input  logic [AW:0]                     I_Fifo_Data_Num,
  input  logic                            I_Fifo_Full,
  output logic                            O_Busy,
  output logic                            O_Len_Err,
  output logic                            O_Ovf_Err
);

  // Space arithmetic width: holds FIFO_DEPTH and Len+1 without truncation.
  localparam int          SW      = AW + 2;
  localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

  arb_state_e             state_q, state_d;
  logic [RW-1:0]          ptr_q, gnt_id_q, win_id;
  logic                   win_vld;
  logic [LEN_WIDTH-1:0]   len_q, cnt_q, win_len;
  logic [REQ_NUM-1:0]     grant_q;
  logic                   len_err_q, ovf_err_q;
  logic [SW-1:0]          free_space, win_need, lat_need;
  logic                   win_too_long, wr_en, last_beat;
  logic [DATA_WIDTH-1:0]  gnt_data;

  function automatic logic [RW-1:0] next_id(input logic [RW-1:0] id);
    return (id == RW'(REQ_NUM - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [REQ_NUM-1:0] one_hot(input logic [RW-1:0] id);
    logic [REQ_NUM-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  ddr_ctrl_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .RW      (RW)
  ) u_pick (
    .req     (I_Req),
    .ptr     (ptr_q),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  // Select the candidate's burst length and the granted requester's beat data.
  always_comb begin
    win_len  = '0;
    gnt_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (win_id == RW'(i)) begin
        win_len = I_Req_Len[i*LEN_WIDTH +: LEN_WIDTH];
      end
      if (gnt_id_q == RW'(i)) begin
        gnt_data = I_Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Admission arithmetic: bursts larger than the FIFO can never fit and are rejected outright.
  always_comb begin
    win_too_long = (32'(win_len) + 32'd1) > DEPTH_U;
    free_space   = SW'(FIFO_DEPTH) - SW'(I_Fifo_Data_Num);
    win_need     = SW'(win_len) + SW'(1);
    lat_need     = SW'(len_q) + SW'(1);
    wr_en        = (state_q == BURST) & I_Data_Vld[gnt_id_q];
    last_beat    = wr_en & (cnt_q == len_q);
  end

  // State register.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_N) begin
    if (!Sys_Rst_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the locked winner waits for room rather than letting others bypass it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_vld && !win_too_long) begin
          state_d = (free_space >= win_need) ? BURST : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (free_space >= lat_need) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched length, beat counter, pointer and error pulses.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_N) begin
    if (!Sys_Rst_N) begin
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      len_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      ovf_err_q <= wr_en & I_Fifo_Full;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            if (win_too_long) begin
              len_err_q <= 1'b1;
              ptr_q     <= next_id(win_id);
            end else begin
              gnt_id_q <= win_id;
              len_q    <= win_len;
              cnt_q    <= '0;
              grant_q  <= one_hot(win_id);
            end
          end
        end
        BURST: begin
          if (wr_en) begin
            if (last_beat) begin
              cnt_q   <= '0;
              grant_q <= '0;
              ptr_q   <= next_id(gnt_id_q);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Write port and per-requester beat acknowledge, live only while bursting.
  always_comb begin
    O_Beat_Ack     = '0;
    O_Fifo_Wr_En   = wr_en;
    O_Fifo_Wr_Data = (state_q == BURST) ? gnt_data : '0;
    if (wr_en) begin
      O_Beat_Ack[gnt_id_q] = 1'b1;
    end
  end

  assign O_Grant   = grant_q;
  assign O_Busy    = (state_q != IDLE);
  assign O_Len_Err = len_err_q;
  assign O_Ovf_Err = ovf_err_q;

endmodule

// File: tb/tb_ddr_ctrl_fifo_arbiter.sv
// Bench for ddr_ctrl_fifo_arbiter: directed vector table, corner sequences, randomized model check.
// Latency: inputs driven at negedge, outputs sampled 2 time units later.
// Backpressure: a tb-side FIFO fill count drains randomly in the random phase.
module tb_ddr_ctrl_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int D  = 8;

  logic            Sys_Clk = 1'b0;
  logic            Sys_Rst_N;
  logic [N-1:0]    I_Req, I_Data_Vld, O_Grant, O_Beat_Ack;
  logic [N*LW-1:0] I_Req_Len;
  logic [N*DW-1:0] I_Req_Data;
  logic            O_Fifo_Wr_En;
  logic [DW-1:0]   O_Fifo_Wr_Data;
  logic [3:0]      I_Fifo_Data_Num;
  logic            I_Fifo_Full, O_Busy, O_Len_Err, O_Ovf_Err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: who owns the FIFO, whether it is waiting for room, beats left, search start.
  int m_owner;
  bit m_wait;
  int m_left;
  int m_ptr;
  bit m_lenerr;
  bit m_ovf;
  int fill;

  ddr_ctrl_fifo_arbiter #(
    .REQ_NUM    (N),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (D)
  ) dut (
    .Sys_Clk         (Sys_Clk),
    .Sys_Rst_N       (Sys_Rst_N),
    .I_Req           (I_Req),
    .I_Req_Len       (I_Req_Len),
    .I_Data_Vld      (I_Data_Vld),
    .I_Req_Data      (I_Req_Data),
    .O_Grant         (O_Grant),
    .O_Beat_Ack      (O_Beat_Ack),
    .O_Fifo_Wr_En    (O_Fifo_Wr_En),
    .O_Fifo_Wr_Data  (O_Fifo_Wr_Data),
    .I_Fifo_Data_Num (I_Fifo_Data_Num),
    .I_Fifo_Full     (I_Fifo_Full),
    .O_Busy          (O_Busy),
    .O_Len_Err       (O_Len_Err),
    .O_Ovf_Err       (O_Ovf_Err)
  );

  always #5 Sys_Clk = ~Sys_Clk;
  always @(posedge Sys_Clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [3:0]      num;
    logic [N-1:0]    g;
    logic            wr;
    logic            b;
    logic            le;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    Sys_Rst_N       = 1'b0;
    I_Req           = '0;
    I_Req_Len       = '0;
    I_Data_Vld      = '0;
    I_Req_Data      = '0;
    I_Fifo_Data_Num = '0;
    I_Fifo_Full     = 1'b0;
    repeat (2) @(negedge Sys_Clk);
    #1;
    chk("rst_grant", 64'(O_Grant), 64'd0);
    chk("rst_busy", 64'(O_Busy), 64'd0);
    chk("rst_wr", 64'(O_Fifo_Wr_En), 64'd0);
    chk("rst_ack", 64'(O_Beat_Ack), 64'd0);
    chk("rst_lenerr", 64'(O_Len_Err), 64'd0);
    chk("rst_ovf", 64'(O_Ovf_Err), 64'd0);
    Sys_Rst_N = 1'b1;
    m_owner = -1; m_wait = 0; m_left = 0; m_ptr = 0; m_lenerr = 0; m_ovf = 0; fill = 0;
  endtask

  task automatic rnd_step();
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ed;
    int            w;
    int            blen;
    bit            nl;
    bit            nov;
    @(negedge Sys_Clk);
    for (int i = 0; i < N; i++) begin
      I_Req[i]                = 1'($urandom_range(0, 1));
      I_Req_Len[i*LW +: LW]   = LW'($urandom_range(0, 9));
      I_Data_Vld[i]           = ($urandom_range(0, 3) != 0);
      I_Req_Data[i*DW +: DW]  = $urandom;
    end
    I_Fifo_Data_Num = 4'(fill);
    I_Fifo_Full     = (fill == D);
    #2;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    ew = (m_owner >= 0) && !m_wait && I_Data_Vld[m_owner];
    ed = ew ? I_Req_Data[m_owner*DW +: DW] : '0;
    chk("rnd_grant", 64'(O_Grant), 64'(eg));
    chk("rnd_wr", 64'(O_Fifo_Wr_En), 64'(ew));
    chk("rnd_ack", 64'(O_Beat_Ack), ew ? 64'(eg) : 64'd0);
    chk("rnd_busy", 64'(O_Busy), 64'(m_owner >= 0));
    chk("rnd_lenerr", 64'(O_Len_Err), 64'(m_lenerr));
    chk("rnd_ovf", 64'(O_Ovf_Err), 64'(m_ovf));
    if (ew) chk("rnd_data", 64'(O_Fifo_Wr_Data), 64'(ed));
    // Advance the model by one clock.
    nl  = 0;
    nov = ew && (fill == D);
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && I_Req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
        blen = int'(I_Req_Len[w*LW +: LW]) + 1;
        if (blen > D) begin
          nl    = 1;
          m_ptr = (w + 1) % N;
        end else begin
          m_owner = w;
          m_left  = blen;
          m_wait  = (D - fill) < blen;
        end
      end
    end else if (m_wait) begin
      if ((D - fill) >= m_left) m_wait = 0;
    end else if (ew) begin
      m_left--;
      if (m_left == 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    m_lenerr = nl;
    m_ovf    = nov;
    if (fill > 0 && $urandom_range(0, 1) == 1) fill--;
    if (ew && fill < D) fill++;
  endtask

  initial begin
    bit        pat[6];
    logic [31:0] got_q[$];
    int        expd[4];
    logic [DW-1:0] ed;

    tbl[0]  = '{4'b0010, 16'h0030, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 16'h0030, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4'b0000, 16'h0030, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 16'h0030, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 16'h0030, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 16'h0030, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1100, 16'h0F00, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1100, 16'h0F00, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{4'b0000, 16'h0F00, 4'd0, 4'b1000, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 16'h0F00, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b0001, 16'h0003, 4'd6, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 16'h0003, 4'd6, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 16'h0003, 4'd4, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 16'h0003, 4'd4, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{4'b0000, 16'h0003, 4'd4, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{4'b0000, 16'h0003, 4'd4, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{4'b0000, 16'h0003, 4'd4, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{4'b0000, 16'h0003, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{4'b0101, 16'h0000, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{4'b0101, 16'h0000, 4'd0, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{4'b0101, 16'h0000, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{4'b0101, 16'h0000, 4'd0, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{4'b0101, 16'h0000, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{4'b0101, 16'h0000, 4'd0, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[24] = '{4'b0000, 16'h0000, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};

    // Directed vector table.
    do_reset();
    I_Req_Data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int r = 0; r < 25; r++) begin
      @(negedge Sys_Clk);
      I_Req           = tbl[r].req;
      I_Req_Len       = tbl[r].len;
      I_Fifo_Data_Num = tbl[r].num;
      I_Data_Vld      = '1;
      #2;
      chk($sformatf("tbl%0d_grant", r), 64'(O_Grant), 64'(tbl[r].g));
      chk($sformatf("tbl%0d_wr", r), 64'(O_Fifo_Wr_En), 64'(tbl[r].wr));
      chk($sformatf("tbl%0d_ack", r), 64'(O_Beat_Ack), tbl[r].wr ? 64'(tbl[r].g) : 64'd0);
      chk($sformatf("tbl%0d_busy", r), 64'(O_Busy), 64'(tbl[r].b));
      chk($sformatf("tbl%0d_lenerr", r), 64'(O_Len_Err), 64'(tbl[r].le));
      if (tbl[r].wr) begin
        ed = '0;
        for (int i = 0; i < N; i++) if (tbl[r].g[i]) ed = 32'hD0 + 32'(i);
        chk($sformatf("tbl%0d_data", r), 64'(O_Fifo_Wr_Data), 64'(ed));
      end
    end

    // Bubbles inside a burst: Vld 1,0,1,0,1,1 gives exactly four ordered writes.
    do_reset();
    pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    expd = '{32'h100, 32'h102, 32'h104, 32'h105};
    @(negedge Sys_Clk);
    I_Req = 4'b0010; I_Req_Len = 16'h0030; I_Data_Vld = '0;
    #2;
    chk("seqA_idle_grant", 64'(O_Grant), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Sys_Clk);
      I_Req      = '0;
      I_Req_Len  = '0;
      I_Data_Vld = {2'b00, pat[k], 1'b0};
      I_Req_Data[63:32] = 32'h100 + 32'(k);
      #2;
      chk("seqA_grant", 64'(O_Grant), 64'b0010);
      chk("seqA_wr", 64'(O_Fifo_Wr_En), 64'(pat[k]));
      if (O_Fifo_Wr_En) got_q.push_back(O_Fifo_Wr_Data);
    end
    @(negedge Sys_Clk);
    #2;
    chk("seqA_done_busy", 64'(O_Busy), 64'd0);
    chk("seqA_nwrites", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      for (int j = 0; j < 4; j++) chk("seqA_data", 64'(got_q[j]), 64'(expd[j]));
    end

    // Reset mid-burst, then re-arbitration restarts from pointer 0.
    @(negedge Sys_Clk);
    I_Req = 4'b1000; I_Req_Len = 16'h3000; I_Data_Vld = '1; I_Req_Data[127:96] = 32'hB0;
    #2;
    chk("seqB_idle", 64'(O_Grant), 64'd0);
    @(negedge Sys_Clk);
    I_Req = '0;
    #2;
    chk("seqB_grant", 64'(O_Grant), 64'b1000);
    chk("seqB_wr1", 64'(O_Fifo_Wr_En), 64'd1);
    @(negedge Sys_Clk);
    #2;
    chk("seqB_wr2", 64'(O_Fifo_Wr_En), 64'd1);
    #1 Sys_Rst_N = 1'b0;
    #1;
    chk("seqB_rst_grant", 64'(O_Grant), 64'd0);
    chk("seqB_rst_busy", 64'(O_Busy), 64'd0);
    chk("seqB_rst_wr", 64'(O_Fifo_Wr_En), 64'd0);
    chk("seqB_rst_ack", 64'(O_Beat_Ack), 64'd0);
    chk("seqB_rst_data", 64'(O_Fifo_Wr_Data), 64'd0);
    @(negedge Sys_Clk);
    Sys_Rst_N = 1'b1; I_Req = 4'b1010; I_Req_Len = 16'h3030;
    #2;
    chk("seqB_rel_idle", 64'(O_Grant), 64'd0);
    @(negedge Sys_Clk);
    I_Req = '0;
    #2;
    chk("seqB_rearb", 64'(O_Grant), 64'b0010);
    for (int t = 0; t < 10 && O_Busy; t++) @(negedge Sys_Clk);
    #2;
    chk("seqB_finish", 64'(O_Busy), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    repeat (3000) rnd_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
